// File: rtl/pipe_trap_ctrl.sv
// Pipeline sequencer for the 5-stage RV64I core: hazard stalls, branch redirect,
// and the drain-then-commit sequences for trap entry and mret.
module pipe_trap_ctrl #(
    parameter int XLEN         = 64,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic            id_load_use_i,
    input  logic            id_ilegl_instr_i,
    input  logic            id_ecall_i,
    input  logic            id_ebreak_i,
    input  logic            id_mret_i,
    input  logic            ex_branch_taken_i,
    input  logic [XLEN-1:0] ex_branch_target_i,
    input  logic            mem_busy_i,
    input  logic [XLEN-1:0] csr_mtvec_i,
    input  logic [XLEN-1:0] csr_mepc_i,
    output logic            if_stall_o,
    output logic            id_stall_o,
    output logic            id_flush_o,
    output logic            ifid_flush_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            trap_wen_o,
    output logic [XLEN-1:0] trap_mepc_o,
    output logic [XLEN-1:0] trap_mcause_o,
    output logic            mret_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DRAIN_TRAP = 3'd1,
        TRAP       = 3'd2,
        DRAIN_MRET = 3'd3,
        MRET       = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  MTVEC_MASK = ~(XLEN'(3));

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [XLEN-1:0]   r_mepc, w_mepc_nxt;
    logic [XLEN-1:0]   r_mcause, w_mcause_nxt;
    logic              w_exc;

    // Cause encoding: illegal beats ebreak beats ecall.
    function automatic logic [XLEN-1:0] cause_sel(input logic ill, input logic ebrk);
        logic [XLEN-1:0] c;
        if (ill) begin
            c = XLEN'(2);
        end else if (ebrk) begin
            c = XLEN'(3);
        end else begin
            c = XLEN'(11);
        end
        return c;
    endfunction

    assign w_exc = id_valid_i & (id_ilegl_instr_i | id_ecall_i | id_ebreak_i);

    // State, drain counter and latched trap information.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mepc   <= '0;
            r_mcause <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mepc   <= w_mepc_nxt;
            r_mcause <= w_mcause_nxt;
        end
    end

    // Next-state and pipeline control outputs.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_mepc_nxt       = r_mepc;
        w_mcause_nxt     = r_mcause;
        if_stall_o       = 1'b0;
        id_stall_o       = 1'b0;
        id_flush_o       = 1'b0;
        ifid_flush_o     = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        trap_wen_o       = 1'b0;
        mret_o           = 1'b0;

        if (mem_busy_i) begin
            // A frozen memory stage freezes everything, including pending sequences.
            if_stall_o = 1'b1;
            id_stall_o = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ex_branch_taken_i) begin
                        redirect_valid_o = 1'b1;
                        redirect_pc_o    = ex_branch_target_i;
                        ifid_flush_o     = 1'b1;
                        id_flush_o       = 1'b1;
                    end else if (w_exc) begin
                        if_stall_o   = 1'b1;
                        id_flush_o   = 1'b1;
                        w_mepc_nxt   = id_pc_i;
                        w_mcause_nxt = cause_sel(id_ilegl_instr_i, id_ebreak_i);
                        w_cnt_nxt    = CNT_LOAD;
                        w_state_nxt  = DRAIN_TRAP;
                    end else if (id_valid_i && id_mret_i) begin
                        if_stall_o  = 1'b1;
                        id_flush_o  = 1'b1;
                        w_cnt_nxt   = CNT_LOAD;
                        w_state_nxt = DRAIN_MRET;
                    end else if (id_valid_i && id_load_use_i) begin
                        if_stall_o = 1'b1;
                        id_flush_o = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                DRAIN_TRAP, DRAIN_MRET: begin
                    if_stall_o = 1'b1;
                    id_flush_o = 1'b1;
                    w_cnt_nxt  = r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        w_state_nxt = (r_state == DRAIN_TRAP) ? TRAP : MRET;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                TRAP: begin
                    trap_wen_o       = 1'b1;
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = csr_mtvec_i & MTVEC_MASK;
                    ifid_flush_o     = 1'b1;
                    id_flush_o       = 1'b1;
                    w_state_nxt      = IDLE;
                end
                MRET: begin
                    mret_o           = 1'b1;
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = csr_mepc_i;
                    ifid_flush_o     = 1'b1;
                    id_flush_o       = 1'b1;
                    w_state_nxt      = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign trap_mepc_o   = r_mepc;
    assign trap_mcause_o = r_mcause;

endmodule

// File: tb/tb_pipe_trap_ctrl.sv
// Scoreboard bench for pipe_trap_ctrl: per-cycle expected control vectors are
// queued as stimulus is applied and compared at the following falling edge.
module tb_pipe_trap_ctrl;

    localparam int XLEN = 64;

    // Control bit order: if_stall, id_stall, id_flush, ifid_flush, redirect, trap_wen, mret
    localparam logic [6:0] F_NONE  = 7'b000_0000;
    localparam logic [6:0] F_STALL = 7'b101_0000;
    localparam logic [6:0] F_BUSY  = 7'b110_0000;
    localparam logic [6:0] F_BR    = 7'b001_1100;
    localparam logic [6:0] F_TRAP  = 7'b001_1110;
    localparam logic [6:0] F_MRET  = 7'b001_1101;

    typedef struct packed {
        logic [6:0]      f;
        logic [XLEN-1:0] pc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid, id_load_use, id_ill, id_ecall, id_ebreak, id_mret;
    logic            br_taken, mem_busy;
    logic [XLEN-1:0] id_pc, br_target, mtvec, mepc_in;
    logic            if_stall, id_stall, id_flush, ifid_flush, redir_v, trap_wen, mret_p;
    logic [XLEN-1:0] redir_pc, trap_mepc, trap_mcause;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    pipe_trap_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(2), .CNT_W(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .id_valid_i(id_valid), .id_pc_i(id_pc), .id_load_use_i(id_load_use),
        .id_ilegl_instr_i(id_ill), .id_ecall_i(id_ecall), .id_ebreak_i(id_ebreak),
        .id_mret_i(id_mret), .ex_branch_taken_i(br_taken), .ex_branch_target_i(br_target),
        .mem_busy_i(mem_busy), .csr_mtvec_i(mtvec), .csr_mepc_i(mepc_in),
        .if_stall_o(if_stall), .id_stall_o(id_stall), .id_flush_o(id_flush),
        .ifid_flush_o(ifid_flush), .redirect_valid_o(redir_v), .redirect_pc_o(redir_pc),
        .trap_wen_o(trap_wen), .trap_mepc_o(trap_mepc), .trap_mcause_o(trap_mcause),
        .mret_o(mret_p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clr_in();
        id_valid = 1'b0; id_load_use = 1'b0; id_ill = 1'b0; id_ecall = 1'b0;
        id_ebreak = 1'b0; id_mret = 1'b0; br_taken = 1'b0; mem_busy = 1'b0;
        id_pc = '0; br_target = '0;
    endtask

    // Inputs are already applied; queue the expectation, then compare mid-cycle.
    task automatic cyc(input string tag, input logic [6:0] f, input logic [XLEN-1:0] pc);
        exp_t e;
        exp_t a;
        sb_q.push_back('{f: f, pc: pc});
        @(negedge clk);
        e = sb_q.pop_front();
        a.f  = {if_stall, id_stall, id_flush, ifid_flush, redir_v, trap_wen, mret_p};
        a.pc = redir_pc;
        chk(tag, 128'(a), 128'(e));
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_in();
        mtvec   = 64'h1001;
        mepc_in = 64'h300;
        rst_n   = 1'b0;
        @(posedge clk); #1;
        cyc("rst_out", F_NONE, 64'h0);
        rst_n = 1'b1;
        chk("rst_mepc", 128'(trap_mepc), 128'h0);
        chk("rst_mcause", 128'(trap_mcause), 128'h0);
        cyc("idle", F_NONE, 64'h0);

        // Load-use: exactly one stall/bubble cycle.
        id_valid = 1'b1; id_pc = 64'h100; id_load_use = 1'b1;
        cyc("lu", F_STALL, 64'h0);
        clr_in();
        cyc("lu_after", F_NONE, 64'h0);
        id_load_use = 1'b1;
        cyc("lu_masked", F_NONE, 64'h0);
        clr_in();

        // Taken branch.
        br_taken = 1'b1; br_target = 64'h8000_0040;
        cyc("br", F_BR, 64'h8000_0040);
        mem_busy = 1'b1;
        cyc("br_busy", F_BUSY, 64'h0);
        clr_in();

        // ecall with flags held in ID during the drain; they must be ignored.
        id_valid = 1'b1; id_pc = 64'h200; id_ecall = 1'b1;
        cyc("ecall_det", F_STALL, 64'h0);
        cyc("ecall_d1", F_STALL, 64'h0);
        cyc("ecall_d2", F_STALL, 64'h0);
        chk("ecall_mepc", 128'(trap_mepc), 128'h200);
        chk("ecall_mcause", 128'(trap_mcause), 128'd11);
        cyc("ecall_trap", F_TRAP, 64'h1000);
        clr_in();
        cyc("ecall_idle", F_NONE, 64'h0);

        // ecall on the wrong path of a taken branch.
        id_valid = 1'b1; id_pc = 64'h220; id_ecall = 1'b1;
        br_taken = 1'b1; br_target = 64'h500;
        cyc("wp_br", F_BR, 64'h500);
        clr_in();
        for (int i = 0; i < 4; i++) cyc("wp_none", F_NONE, 64'h0);
        chk("wp_mepc", 128'(trap_mepc), 128'h200);

        // ebreak with three frozen cycles inside the drain.
        id_valid = 1'b1; id_pc = 64'h240; id_ebreak = 1'b1;
        cyc("ebrk_det", F_STALL, 64'h0);
        clr_in();
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) cyc("ebrk_busy", F_BUSY, 64'h0);
        mem_busy = 1'b0;
        cyc("ebrk_d1", F_STALL, 64'h0);
        cyc("ebrk_d2", F_STALL, 64'h0);
        cyc("ebrk_trap", F_TRAP, 64'h1000);
        chk("ebrk_mcause", 128'(trap_mcause), 128'd3);
        chk("ebrk_mepc", 128'(trap_mepc), 128'h240);
        cyc("ebrk_idle", F_NONE, 64'h0);

        // Illegal outranks ecall in the cause encoding.
        id_valid = 1'b1; id_pc = 64'h260; id_ill = 1'b1; id_ecall = 1'b1;
        cyc("ill_det", F_STALL, 64'h0);
        clr_in();
        cyc("ill_d1", F_STALL, 64'h0);
        cyc("ill_d2", F_STALL, 64'h0);
        chk("ill_mcause", 128'(trap_mcause), 128'd2);
        cyc("ill_trap", F_TRAP, 64'h1000);

        // mret returns to mepc; trap registers untouched.
        id_valid = 1'b1; id_pc = 64'h280; id_mret = 1'b1;
        cyc("mret_det", F_STALL, 64'h0);
        clr_in();
        cyc("mret_d1", F_STALL, 64'h0);
        cyc("mret_d2", F_STALL, 64'h0);
        cyc("mret_go", F_MRET, 64'h300);
        cyc("mret_idle", F_NONE, 64'h0);
        chk("mret_mepc", 128'(trap_mepc), 128'h260);

        // Reset during the drain abandons the trap.
        id_valid = 1'b1; id_pc = 64'h400; id_ecall = 1'b1;
        cyc("rd_det", F_STALL, 64'h0);
        clr_in();
        rst_n = 1'b0;
        cyc("rd_d1", F_STALL, 64'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc("rd_none", F_NONE, 64'h0);
        chk("rd_mepc", 128'(trap_mepc), 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
